arc_plotter: RTL
================

Name: arc_plotter

Overview:
- Parametrised successor to the lab circle/Reuleaux drawers: rasterises a midpoint circle with a per-octant enable mask, so one engine serves full circles and Reuleaux arc segments.
- Clips every pixel to the screen.
- Stalls on a downstream ready signal, so it can share a framebuffer port behind an arbiter.
- Sits between the task-level FSM and the VGA adapter / plot arbiter.

Parameters:
- X_W, 8, width of x coordinates
- Y_W, 7, width of y coordinates
- R_W, 8, width of radius
- SCREEN_W, 160, pixels per row; visible x range is 0..SCREEN_W-1
- SCREEN_H, 120, rows; visible y range is 0..SCREEN_H-1
- COLOUR_W, 3, colour width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a draw; level-sensitive
- centre_x  in  X_W  centre x, sampled on the accepted start
- centre_y  in  Y_W  centre y, sampled on the accepted start
- radius  in  R_W  radius, sampled on the accepted start
- octant_mask  in  8  slot enables, bit k enables slot k; sampled on the accepted start
- colour  in  COLOUR_W  colour, sampled on the accepted start
- plot_ready  in  1  downstream accepts the pixel on this edge
- done  out  1  draw complete
- vga_x  out  X_W  pixel x
- vga_y  out  Y_W  pixel y
- vga_colour  out  COLOUR_W  pixel colour
- vga_plot  out  1  pixel valid

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; done, vga_plot, vga_x, vga_y and vga_colour are all 0. Reset mid-draw aborts immediately and nothing further is plotted.
- States: IDLE, INIT, PLOT, STEP, DONE.
- IDLE: when start=1, latch all inputs and go to INIT.
- INIT (1 cycle): set ox=radius, oy=0, crit=1-radius, slot=0, then go to PLOT.
  - ox, oy and crit are signed, width R_W+2.
- PLOT: one slot per cycle, slot 0..7, producing:
  - slot 0: (cx+ox, cy+oy)
  - slot 1: (cx+oy, cy+ox)
  - slot 2: (cx-ox, cy+oy)
  - slot 3: (cx-oy, cy+ox)
  - slot 4: (cx-ox, cy-oy)
  - slot 5: (cx-oy, cy-ox)
  - slot 6: (cx+ox, cy-oy)
  - slot 7: (cx+oy, cy-ox)
- Coordinate arithmetic is signed at width max(X_W,Y_W)+2.
  - A slot is visible only if its mask bit is 1 and 0<=x<SCREEN_W and 0<=y<SCREEN_H.
- Visible slot: vga_plot=1 with coordinates truncated to X_W/Y_W.
  - The slot is held (outputs stable) until a rising edge with plot_ready=1, then advances.
- Invisible slot: vga_plot=0 and the slot advances in 1 cycle regardless of plot_ready.
- After slot 7 completes, go to STEP; vga_plot=0 in STEP.
- STEP (1 cycle):
  - oy=oy+1.
  - If crit<=0: crit=crit+2*oy+1, using the new oy.
  - Else: ox=ox-1 and crit=crit+2*(oy-ox)+1, using the new oy and ox.
  - Then if oy<=ox go to PLOT with slot=0, else go to DONE.
- DONE: done=1 and vga_plot=0. Stay while start=1; go to IDLE when start=0.
  - done is registered and goes high the cycle after the final STEP.
- start while busy (INIT/PLOT/STEP) is ignored; inputs changing mid-draw have no effect.
- radius=0: one iteration; all enabled slots plot (cx,cy), 8 duplicates with a full mask.
- Cycle count with plot_ready tied high: 1 (INIT) + N*9 + 1 to done, where N is the iteration count.
- The draw order is fixed; duplicate pixels at octant boundaries are emitted and not filtered.

Test Plan:
- Reset, then start with centre (80,60), radius 10, mask 8'hFF, colour 2, ready=1 -> first plotted pixels (90,60), (80,70), (70,60), (80,70); vga_colour=2.
- Radius 1, centre (80,60), mask FF, ready=1 -> N=2, exactly 16 vga_plot pulses; done rises on cycle 20 after start acceptance; done holds until start drops, then IDLE.
- Centre (2,2), radius 5, mask FF -> slot-2 pixel (-3,2) suppressed with vga_plot=0 in its cycle; no plotted pixel has x>=160 or y>=120.
- Mask 8'b0000_0001, centre (80,60), radius 10 -> every pulse has x>=80 and y>=60; first pixel is (90,60).
- Radius 10, plot_ready toggling 0/1 every other cycle -> same pixel sequence as the ready=1 run; outputs are stable while ready=0.
- Deassert rst_n mid-PLOT -> vga_plot=0 and done=0 immediately; no pixel is emitted until a new start.

Source files
------------

// File: rtl/arc_plotter.sv
// arc_plotter: midpoint circle rasteriser with a per-slot enable mask and screen clipping.
// Latency: 1 INIT cycle, then 9 cycles per iteration (8 slots + STEP) with ready high; done one cycle after the last STEP.
// Backpressure: a visible pixel holds vga_* stable until plot_ready is high on a rising edge; clipped slots never wait.
module arc_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [X_W-1:0]      centre_x,
  input  logic [Y_W-1:0]      centre_y,
  input  logic [R_W-1:0]      radius,
  input  logic [7:0]          octant_mask,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                plot_ready,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  // Coordinate width leaves room for a sign bit and one bit of overflow
  // past either screen edge; the midpoint variables carry the same margin.
  localparam int C_W = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int D_W = R_W + 2;

  localparam logic signed [D_W-1:0] ZERO  = '0;
  localparam logic signed [D_W-1:0] ONE   = D_W'(1);
  localparam logic signed [C_W-1:0] SCR_W = C_W'(SCREEN_W);
  localparam logic signed [C_W-1:0] SCR_H = C_W'(SCREEN_H);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PLOT,
    STEP,
    DONE
  } state_t;

  // Draw request captured on the accepted start; frozen for the whole draw.
  typedef struct packed {
    logic [X_W-1:0]      cx;
    logic [Y_W-1:0]      cy;
    logic [R_W-1:0]      r;
    logic [7:0]          mask;
    logic [COLOUR_W-1:0] col;
  } job_t;

  state_t state, state_n;
  job_t   job, job_n;

  logic signed [D_W-1:0] ox, oy, crit;
  logic signed [D_W-1:0] ox_n, oy_n, crit_n;
  logic [2:0]            slot, slot_n;

  // Midpoint step terms, evaluated every cycle and used only in STEP.
  logic signed [D_W-1:0] oy_inc, ox_dec, step_ox, step_crit;
  logic                  crit_le0;

  // Current slot's pixel in signed screen space.
  logic signed [C_W-1:0] cx_s, cy_s, ox_s, oy_s, px, py;
  logic                  in_x, in_y, slot_vis, plotting;

  assign oy_inc    = oy + ONE;
  assign ox_dec    = ox - ONE;
  assign crit_le0  = (crit <= ZERO);
  assign step_ox   = crit_le0 ? ox : ox_dec;
  assign step_crit = crit_le0 ? (crit + (oy_inc <<< 1) + ONE)
                              : (crit + ((oy_inc - ox_dec) <<< 1) + ONE);

  assign cx_s = $signed({{(C_W-X_W){1'b0}}, job.cx});
  assign cy_s = $signed({{(C_W-Y_W){1'b0}}, job.cy});
  assign ox_s = C_W'(ox);
  assign oy_s = C_W'(oy);

  // Map the slot number onto one of the eight symmetric points.
  always_comb begin
    px = cx_s;
    py = cy_s;
    case (slot)
      3'd0: begin px = cx_s + ox_s; py = cy_s + oy_s; end
      3'd1: begin px = cx_s + oy_s; py = cy_s + ox_s; end
      3'd2: begin px = cx_s - ox_s; py = cy_s + oy_s; end
      3'd3: begin px = cx_s - oy_s; py = cy_s + ox_s; end
      3'd4: begin px = cx_s - ox_s; py = cy_s - oy_s; end
      3'd5: begin px = cx_s - oy_s; py = cy_s - ox_s; end
      3'd6: begin px = cx_s + ox_s; py = cy_s - oy_s; end
      3'd7: begin px = cx_s + oy_s; py = cy_s - ox_s; end
      default: begin px = cx_s; py = cy_s; end
    endcase
  end

  assign in_x     = !px[C_W-1] && (px < SCR_W);
  assign in_y     = !py[C_W-1] && (py < SCR_H);
  assign slot_vis = job.mask[slot] && in_x && in_y;
  assign plotting = (state == PLOT) && slot_vis;

  // Outputs are zero whenever no pixel is offered, so reset clears them at once.
  assign vga_plot   = plotting;
  assign vga_x      = plotting ? px[X_W-1:0] : '0;
  assign vga_y      = plotting ? py[Y_W-1:0] : '0;
  assign vga_colour = plotting ? job.col : '0;

  // Next-state and datapath update for each phase of the draw.
  always_comb begin
    state_n = state;
    job_n   = job;
    ox_n    = ox;
    oy_n    = oy;
    crit_n  = crit;
    slot_n  = slot;
    case (state)
      IDLE: begin
        if (start) begin
          job_n.cx   = centre_x;
          job_n.cy   = centre_y;
          job_n.r    = radius;
          job_n.mask = octant_mask;
          job_n.col  = colour;
          state_n    = INIT;
        end
      end
      INIT: begin
        ox_n    = $signed({2'b00, job.r});
        oy_n    = ZERO;
        crit_n  = ONE - $signed({2'b00, job.r});
        slot_n  = 3'd0;
        state_n = PLOT;
      end
      PLOT: begin
        // Clipped or masked slots are skipped without waiting for ready.
        if (!slot_vis || plot_ready) begin
          slot_n = slot + 3'd1;
          if (slot == 3'd7) begin
            state_n = STEP;
          end
        end
      end
      STEP: begin
        oy_n    = oy_inc;
        ox_n    = step_ox;
        crit_n  = step_crit;
        slot_n  = 3'd0;
        state_n = (oy_inc <= step_ox) ? PLOT : DONE;
      end
      DONE: begin
        if (!start) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; an asynchronous reset abandons any draw in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath registers plus the registered done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job  <= '0;
      ox   <= '0;
      oy   <= '0;
      crit <= '0;
      slot <= '0;
      done <= 1'b0;
    end else begin
      job  <= job_n;
      ox   <= ox_n;
      oy   <= oy_n;
      crit <= crit_n;
      slot <= slot_n;
      done <= (state_n == DONE);
    end
  end

endmodule
